// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Request/response and data-memory bus bundle for the
//                load/store access unit. The slave modport is the unit's view;
//                the master modport is the view of the MEM stage + memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int NB = DATA_W / 8;

   // MEM-stage request
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   // Completion back to the MEM stage
   logic              resp_valid;
   logic              resp_err;
   logic [DATA_W-1:0] resp_rdata;

   // Data memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [NB-1:0]     mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_err, resp_rdata,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_err, resp_rdata,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Sequential load/store access unit between the MEM stage and
//                the data memory port. Generates byte-lane enables and
//                replicated store data, flags misaligned/illegal accesses,
//                runs a grant/rvalid memory handshake and returns sign- or
//                zero-extended load data with a one-cycle response pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int DATA_W = 32,   // 32 or 64
   parameter int ADDR_W = 32
) (
   input  wire logic         clk,
   input  wire logic         reset_n,
   mem_access_unit_if.slave  bus
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // State and latched request
   // ------------------------------------------------------------------------
   state_t             state_q;
   logic               we_q;
   logic [1:0]         size_q;
   logic               signed_q;
   logic [OFF_W-1:0]   off_q;

   // Registered outputs
   logic               req_ready_q;
   logic               resp_valid_q;
   logic               resp_err_q;
   logic [DATA_W-1:0]  resp_rdata_q;
   logic               mem_req_q;
   logic               mem_we_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [NB-1:0]      mem_be_q;
   logic [DATA_W-1:0]  mem_wdata_q;

   // Values derived from the incoming request at accept time
   logic               illegal_d;
   logic [OFF_W-1:0]   off_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [NB-1:0]      be_d;
   logic [DATA_W-1:0]  wdata_d;

   // Load extraction from the raw memory word using the latched request
   logic [DATA_W-1:0]  shifted_d;
   logic [DATA_W-1:0]  mask_d;
   logic               sign_d;
   logic [DATA_W-1:0]  ext_d;

   assign off_d  = bus.req_addr[OFF_W-1:0];
   assign addr_d = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // Alignment check: address must be a multiple of the access size, and a
   // doubleword access only exists on a 64-bit bus.
   always_comb begin
      illegal_d = 1'b0;
      case (bus.req_size)
         2'd0:    illegal_d = 1'b0;
         2'd1:    illegal_d = bus.req_addr[0];
         2'd2:    illegal_d = |bus.req_addr[1:0];
         default: illegal_d = (DATA_W == 32) || (|bus.req_addr[2:0]);
      endcase
   end

   // Byte-lane enables positioned at the lane offset of the access
   always_comb begin
      be_d = '0;
      case (bus.req_size)
         2'd0:    be_d = NB'(1'b1)  << off_d;
         2'd1:    be_d = NB'(2'b11) << off_d;
         2'd2:    be_d = NB'(4'hF)  << off_d;
         default: be_d = '1;
      endcase
   end

   // Store data: the low 8/16/32 bits are copied into every lane group so the
   // enabled lanes always carry the right bytes regardless of offset.
   for (genvar i = 0; i < NB; i++) begin : g_lane
      logic [7:0] lane_byte;

      // Select the source byte for lane i according to the access size
      always_comb begin
         case (bus.req_size)
            2'd0:    lane_byte = bus.req_wdata[7:0];
            2'd1:    lane_byte = bus.req_wdata[8*(i%2) +: 8];
            2'd2:    lane_byte = bus.req_wdata[8*(i%4) +: 8];
            default: lane_byte = bus.req_wdata[8*i +: 8];
         endcase
      end

      assign wdata_d[8*i +: 8] = lane_byte;
   end

   // Right-justify the addressed field and extend it to the full bus width
   always_comb begin
      shifted_d = bus.mem_rdata >> {off_q, 3'b000};
      mask_d    = '1;
      sign_d    = 1'b0;
      case (size_q)
         2'd0: begin
            mask_d = DATA_W'(8'hFF);
            sign_d = shifted_d[7];
         end
         2'd1: begin
            mask_d = DATA_W'(16'hFFFF);
            sign_d = shifted_d[15];
         end
         2'd2: begin
            mask_d = DATA_W'(32'hFFFF_FFFF);
            sign_d = shifted_d[31];
         end
         default: begin
            mask_d = '1;
            sign_d = 1'b0;
         end
      endcase
      ext_d = (shifted_d & mask_d) | ((signed_q & sign_d) ? ~mask_d : '0);
   end

   // Access FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'd0;
         signed_q     <= 1'b0;
         off_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  we_q        <= bus.req_we;
                  size_q      <= bus.req_size;
                  signed_q    <= bus.req_signed;
                  off_q       <= off_d;
                  req_ready_q <= 1'b0;
                  if (illegal_d) begin
                     // Illegal accesses never reach memory
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= '0;
                  end else begin
                     state_q     <= S_REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= bus.req_we;
                     mem_addr_q  <= addr_d;
                     mem_be_q    <= be_d;
                     mem_wdata_q <= wdata_d;
                  end
               end
            end

            S_REQ: begin
               if (bus.mem_gnt) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_be_q    <= '0;
                  mem_wdata_q <= '0;
                  if (we_q) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= '0;
                  end else if (bus.mem_rvalid) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b0;
                     resp_rdata_q <= ext_d;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= ext_d;
               end
            end

            default: begin
               // Response pulse has been shown for one cycle; rdata is held
               state_q     <= S_IDLE;
               resp_err_q  <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit. A 32-bit and a
//                64-bit instance sit side by side; sel64 routes stimulus to
//                one of them and muxes its outputs for checking against a
//                behavioural model of the access rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   // Shared stimulus
   logic        sel64      = 1'b0;
   logic        req_valid  = 1'b0;
   logic        req_we     = 1'b0;
   logic [1:0]  req_size   = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr   = 32'd0;
   logic [63:0] req_wdata  = 64'd0;
   logic        mem_gnt    = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata  = 64'd0;

   int n_chk  = 0;
   int n_pass = 0;

   mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) if32 ();
   mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) if64 ();

   assign if32.req_valid  = req_valid & ~sel64;
   assign if32.req_we     = req_we;
   assign if32.req_size   = req_size;
   assign if32.req_signed = req_signed;
   assign if32.req_addr   = req_addr;
   assign if32.req_wdata  = req_wdata[31:0];
   assign if32.mem_gnt    = mem_gnt & ~sel64;
   assign if32.mem_rvalid = mem_rvalid & ~sel64;
   assign if32.mem_rdata  = mem_rdata[31:0];

   assign if64.req_valid  = req_valid & sel64;
   assign if64.req_we     = req_we;
   assign if64.req_size   = req_size;
   assign if64.req_signed = req_signed;
   assign if64.req_addr   = req_addr;
   assign if64.req_wdata  = req_wdata;
   assign if64.mem_gnt    = mem_gnt & sel64;
   assign if64.mem_rvalid = mem_rvalid & sel64;
   assign if64.mem_rdata  = mem_rdata;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if32)
   );

   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if64)
   );

   // Observed outputs of whichever instance is selected
   logic        o_ready, o_rv, o_err, o_mreq, o_mwe;
   logic [63:0] o_rdata, o_mwd;
   logic [31:0] o_maddr;
   logic [7:0]  o_be;

   always_comb begin
      if (sel64) begin
         o_ready = if64.req_ready;
         o_rv    = if64.resp_valid;
         o_err   = if64.resp_err;
         o_rdata = if64.resp_rdata;
         o_mreq  = if64.mem_req;
         o_mwe   = if64.mem_we;
         o_maddr = if64.mem_addr;
         o_be    = if64.mem_be;
         o_mwd   = if64.mem_wdata;
      end else begin
         o_ready = if32.req_ready;
         o_rv    = if32.resp_valid;
         o_err   = if32.resp_err;
         o_rdata = {32'd0, if32.resp_rdata};
         o_mreq  = if32.mem_req;
         o_mwe   = if32.mem_we;
         o_maddr = if32.mem_addr;
         o_be    = {4'd0, if32.mem_be};
         o_mwd   = {32'd0, if32.mem_wdata};
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
   endtask

   // Behavioural model: expected memory-side values and extended load data
   function automatic void model(input bit w64, input logic [1:0] sz, input bit sgn,
                                 input logic [31:0] addr, input logic [63:0] wd,
                                 input logic [63:0] rd, output bit err,
                                 output logic [31:0] ea, output logic [7:0] eb,
                                 output logic [63:0] ewd, output logic [63:0] erd);
      int nb, bytes, o;
      logic [127:0] f;
      nb    = w64 ? 8 : 4;
      bytes = 1 << sz;
      o     = int'(addr % nb);
      err   = ((addr % bytes) != 0) || (sz == 2'd3 && !w64);
      ea    = addr - 32'(o);
      eb    = 8'd0;
      ewd   = 64'd0;
      for (int i = 0; i < nb; i++) begin
         if (i >= o && i < o + bytes) eb[i] = 1'b1;
         ewd[8*i +: 8] = wd[8*(i % bytes) +: 8];
      end
      f = w64 ? {64'd0, rd} : {96'd0, rd[31:0]};
      f = (f >> (8*o)) % (128'd1 << (8*bytes));
      if (sgn && f >= (128'd1 << (8*bytes - 1))) f = f - (128'd1 << (8*bytes));
      erd = w64 ? f[63:0] : {32'd0, f[31:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One complete access with a chosen grant delay and rvalid delay
   task automatic do_txn(input bit w64, input bit we, input logic [1:0] sz, input bit sgn,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input int gdly, input int rdly, input bit stale);
      bit          err;
      logic [31:0] ea;
      logic [7:0]  eb;
      logic [63:0] ewd, erd, exp_rd;
      model(w64, sz, sgn, addr, wd, rd, err, ea, eb, ewd, erd);
      exp_rd = (we || err) ? 64'd0 : erd;
      sel64 = w64;
      #1;
      chk("ready_idle", o_ready, 1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
      req_addr = addr; req_wdata = wd;
      step();
      // Scramble request fields so only latched values can be correct
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};
      #1;
      if (err) begin
         chk("err_valid", o_rv, 1);
         chk("err_flag", o_err, 1);
         chk("err_rdata", o_rdata, 0);
         chk("err_no_mreq", o_mreq, 0);
         chk("err_busy", o_ready, 0);
      end else begin
         for (int k = 0; k <= gdly; k++) begin
            chk("mreq", o_mreq, 1);
            chk("maddr", o_maddr, ea);
            chk("mbe", o_be, eb);
            chk("mwe", o_mwe, we);
            if (we) chk("mwdata", o_mwd, ewd);
            chk("busy", o_ready, 0);
            chk("no_early_resp", o_rv, 0);
            mem_gnt = (k == gdly);
            if (k == gdly && !we && rdly == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd;
            end
            step();
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            #1;
         end
         if (!we) begin
            for (int k = 1; k <= rdly; k++) begin
               chk("wait_no_mreq", o_mreq, 0);
               chk("wait_no_resp", o_rv, 0);
               if (k == rdly) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = rd;
               end
               step();
               mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
               #1;
            end
         end
         chk("resp_valid", o_rv, 1);
         chk("resp_err", o_err, 0);
         chk("resp_rdata", o_rdata, exp_rd);
      end
      if (stale) begin
         mem_rvalid = 1'b1;
         mem_rdata  = {$urandom, $urandom};
      end
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("resp_pulse", o_rv, 0);
      chk("ready_back", o_ready, 1);
      chk("rdata_hold", o_rdata, exp_rd);
      if (stale) begin
         mem_rvalid = 1'b1;
         step();
         mem_rvalid = 1'b0;
         #1;
         chk("stale_no_resp", o_rv, 0);
         chk("stale_hold", o_rdata, exp_rd);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready"}, o_ready, 1);
      chk({tag, "_rv"}, o_rv, 0);
      chk({tag, "_err"}, o_err, 0);
      chk({tag, "_rdata"}, o_rdata, 0);
      chk({tag, "_mreq"}, o_mreq, 0);
      chk({tag, "_mwe"}, o_mwe, 0);
      chk({tag, "_maddr"}, o_maddr, 0);
      chk({tag, "_mbe"}, o_be, 0);
      chk({tag, "_mwd"}, o_mwd, 0);
   endtask

   // Reset asserted while a load is in REQ or WAIT; stale rvalid afterwards
   task automatic reset_mid(input bit in_wait);
      sel64 = 1'b0;
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h0000_5004;
      step();
      req_valid = 1'b0;
      #1;
      chk("mid_req_mreq", o_mreq, 1);
      if (in_wait) begin
         mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
         #1;
         chk("mid_wait_mreq", o_mreq, 0);
      end
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = {$urandom, $urandom};
      #1;
      check_reset_state(in_wait ? "rst_wait" : "rst_req");
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("rst_no_resp", o_rv, 0);
      chk("rst_ready", o_ready, 1);
   endtask

   initial begin
      bit          w;
      logic [1:0]  s;
      logic [31:0] a;

      repeat (3) @(posedge clk);
      @(negedge clk);
      sel64 = 1'b0; #1;
      check_reset_state("reset32");
      sel64 = 1'b1; #1;
      check_reset_state("reset64");
      reset_n = 1'b1;
      @(negedge clk);

      // Directed vectors (32-bit bus)
      do_txn(0, 1, 2'd0, 0, 32'h0000_1003, 64'h0000_00AB, 64'd0, 0, 0, 0);
      do_txn(0, 0, 2'd1, 1, 32'h0000_2002, 64'd0, 64'h8001_1234, 0, 1, 0);
      do_txn(0, 0, 2'd1, 0, 32'h0000_2002, 64'd0, 64'h8001_1234, 0, 1, 0);
      do_txn(0, 0, 2'd0, 0, 32'h0000_2001, 64'd0, 64'h8001_1234, 0, 0, 1);
      do_txn(0, 0, 2'd2, 0, 32'h0000_3001, 64'd0, 64'd0, 0, 0, 0);
      do_txn(0, 1, 2'd2, 0, 32'h0000_4000, 64'hDEAD_BEEF, 64'd0, 3, 0, 0);
      do_txn(0, 1, 2'd3, 0, 32'h0000_0008, 64'h1122_3344_5566_7788, 64'd0, 0, 0, 0);

      // Reset during an outstanding access
      do_txn(0, 0, 2'd0, 1, 32'h0000_6003, 64'd0, 64'h9A00_0000, 0, 0, 0);
      reset_mid(1'b1);
      do_txn(0, 0, 2'd2, 1, 32'h0000_7000, 64'd0, 64'hF000_0001, 1, 2, 0);
      reset_mid(1'b0);

      // Directed vectors (64-bit bus)
      do_txn(1, 1, 2'd3, 0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'd0, 0, 0, 0);
      do_txn(1, 1, 2'd2, 0, 32'h0000_000C, 64'h0000_0000_1234_5678, 64'd0, 1, 0, 0);
      do_txn(1, 0, 2'd2, 1, 32'h0000_0014, 64'd0, 64'h8765_4321_0000_0000, 0, 1, 0);
      do_txn(1, 0, 2'd3, 1, 32'h0000_0010, 64'd0, 64'hFEDC_BA98_7654_3210, 2, 0, 1);

      // Randomized accesses on both widths
      for (int n = 0; n < 300; n++) begin
         w = 1'($urandom_range(0, 1));
         s = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
         do_txn(w, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
